// File: rtl/opcode_pkg.sv
// opcode_pkg: RV32I major opcodes (instr[6:0]) shared by decode, execute and fetch control.
package opcode_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_OP     = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

endpackage

// File: rtl/pc_pkg.sv
// pc_pkg: sequencer FSM states, branch condition encodings and fetch constants
// shared by pc_sequencer and branch_cmp.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  localparam int INSTR_BYTES_DEFAULT = 4;
  localparam int LINK_OFFSET         = 4;

  // JALR clears bit 0 of the computed target; sliced to XLEN at the use site.
  localparam logic [63:0] JALR_MASK = 64'hFFFF_FFFF_FFFF_FFFE;

endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: combinational RV32I branch condition evaluator (rs1, rs2, funct3 -> taken).
// Encodings outside the six defined branch conditions resolve to not-taken.
module branch_cmp
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [2:0]      funct3_i,
  output logic            taken_o
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1_i == rs2_i);
  assign lt_s = ($signed(rs1_i) < $signed(rs2_i));
  assign lt_u = (rs1_i < rs2_i);

  always_comb begin
    // NOTE: taken_o is defaulted before the case so no encoding can leave it unassigned and infer a latch.
    taken_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = eq;
      F3_BNE:  taken_o = !eq;
      F3_BLT:  taken_o = lt_s;
      F3_BGE:  taken_o = !lt_s;
      F3_BLTU: taken_o = lt_u;
      F3_BGEU: taken_o = !lt_u;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC holder with valid/ready handshake, JAL/JALR/branch and trap redirects.
// Optional macro MISALIGN_TRAP_EN: misaligned targets are reported instead of silently aligned.
module pc_sequencer
  import pc_pkg::*;
  import opcode_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INSTR_BYTES  = INSTR_BYTES_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enbl_i,
  input  logic            fetch_ready_i,
  input  logic            ex_valid_i,
  input  opcode_e         opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] sb_imm_i,
  input  logic [XLEN-1:0] uj_imm_i,
  input  logic [XLEN-1:0] i_imm_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] link_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;

  logic            br_taken;
  logic            taken;
  logic            xfer;
  logic [XLEN-1:0] target_raw;
  logic [XLEN-1:0] target;

  branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .funct3_i (funct3_i),
    .taken_o  (br_taken)
  );

  // Target selection and taken decision for the instruction sitting in execute.
  always_comb begin
    target_raw = ex_pc_i + sb_imm_i;
    taken      = 1'b0;
    case (opcode_i)
      OP_JAL: begin
        target_raw = ex_pc_i + uj_imm_i;
        taken      = ex_valid_i;
      end
      OP_JALR: begin
        target_raw = (rs1_i + i_imm_i) & JALR_MASK[XLEN-1:0];
        taken      = ex_valid_i;
      end
      OP_BRANCH: begin
        target_raw = ex_pc_i + sb_imm_i;
        taken      = ex_valid_i && br_taken;
      end
      default: begin
        target_raw = ex_pc_i + sb_imm_i;
        taken      = 1'b0;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic            misalign_hit;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

  // A misaligned target suppresses the transfer; a trap in the same cycle outranks the report.
  always_comb begin
    misalign_hit    = taken && (target_raw[1:0] != 2'b00);
    xfer            = taken && !misalign_hit;
    target          = target_raw;
    misalign_d      = misalign_hit && !trap_i;
    misalign_addr_d = misalign_d ? target_raw : misalign_addr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;
`else
  always_comb begin
    xfer   = taken;
    target = target_raw & ~XLEN'(3);
  end

  assign misalign_o      = 1'b0;
  assign misalign_addr_o = '0;
`endif

  assign redirect_o = !rst_i && (trap_i || xfer);
  assign link_o     = rst_i ? '0 : (ex_pc_i + XLEN'(LINK_OFFSET));

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = enbl_i ? RUN : HALT;
      RUN:     if (!enbl_i) state_d = HALT;
      HALT:    if (enbl_i)  state_d = RUN;
      default: state_d = BOOT;
    endcase
    pc_valid_d = (state_d == RUN);

    // Redirects bypass the handshake and the FSM; only an accepted fetch advances sequentially.
    pc_d = pc_q;
    if (trap_i) begin
      pc_d = trap_vec_i;
    end else if (xfer) begin
      pc_d = target;
    end else if (pc_valid_q && fetch_ready_i) begin
      pc_d = pc_q + XLEN'(INSTR_BYTES);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_valid_o = pc_valid_q;

endmodule
